// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT address/twiddle sequencer: FSM encoding,
// stage-number width, the default transform size and a counter-width helper.
package ntt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int STAGE_W       = 5;
  localparam int DEFAULT_LOG_N = 3;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int width_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Address and twiddle-index sequencer for an in-place radix-2 DIT NTT of
// N = 2^LOG_N points. Emits one butterfly (addr_a, addr_b, tw_idx) per
// valid/ready handshake, stage by stage, with a drain gap between stages so
// the butterfly results land in RAM before the next stage reads them.
// Every output is a register; out_ready only steers the next-state logic.
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int LOG_N        = DEFAULT_LOG_N,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LOG_N-1:0]   addr_a,
  output logic [LOG_N-1:0]   addr_b,
  output logic [LOG_N-2:0]   tw_idx,
  output logic [STAGE_W-1:0] stage,
  output logic               last_in_stage
);

  localparam int KW = LOG_N - 1;                  // butterfly counter width
  localparam int DW = width_for(DRAIN_CYCLES);    // drain counter width

  localparam logic [KW-1:0]      K_LAST     = '1;  // N/2-1
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG_N - 1);
  localparam logic [DW-1:0]      DRAIN_LAST =
    DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  typedef struct packed {
    logic [LOG_N-1:0] a;
    logic [LOG_N-1:0] b;
    logic [KW-1:0]    tw;
  } bfly_t;

  // Butterfly k of stage s: j = k mod 2^s selects the position inside a
  // group, the group index k >> s is spread apart by one extra bit so the
  // pair (a, a + 2^s) never overlaps another group's pair.
  function automatic bfly_t bfly_addr(input logic [STAGE_W-1:0] s,
                                      input logic [KW-1:0]      k);
    logic [LOG_N-1:0]   kk;
    logic [LOG_N-1:0]   half;
    logic [LOG_N-1:0]   mask;
    logic [LOG_N-1:0]   a;
    logic [KW-1:0]      j;
    logic [STAGE_W-1:0] tw_sh;
    kk    = {1'b0, k};
    half  = LOG_N'(1) << s;
    mask  = half - LOG_N'(1);
    a     = ((kk & ~mask) << 1) | (kk & mask);
    j     = KW'(kk & mask);          // j < 2^s <= N/2, fits in KW bits
    tw_sh = STAGE_W'(KW) - s;        // s <= LOG_N-1, never negative
    return '{a: a, b: a | half, tw: j << tw_sh};
  endfunction

  state_t             r_state, w_state_nxt;
  logic [KW-1:0]      r_k, w_k_nxt;
  logic [STAGE_W-1:0] r_stage, w_stage_nxt;
  logic [DW-1:0]      r_drain, w_drain_nxt;
  logic               w_handshake;
  logic               w_stage_end;
  logic               w_run_nxt;
  bfly_t              w_bfly;

  logic               r_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_last;
  logic [LOG_N-1:0]   r_addr_a;
  logic [LOG_N-1:0]   r_addr_b;
  logic [KW-1:0]      r_tw;

  assign w_handshake = r_valid & out_ready;

  // Next-state logic: butterfly counter, drain counter and stage advance.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_stage_nxt = r_stage;
    w_drain_nxt = r_drain;
    w_stage_end = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_stage_nxt = '0;
          w_k_nxt     = '0;
        end
      end
      ST_RUN: begin
        if (w_handshake) begin
          if (r_k == K_LAST) begin
            if (DRAIN_CYCLES == 0) begin
              w_stage_end = 1'b1;
            end else begin
              w_state_nxt = ST_DRAIN;
              w_drain_nxt = '0;
            end
          end else begin
            w_k_nxt = r_k + KW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          w_stage_end = 1'b1;
        end else begin
          w_drain_nxt = r_drain + DW'(1);
        end
      end
      ST_DONE: begin
        // start is not looked at here: a new transform needs IDLE first.
        w_state_nxt = ST_IDLE;
        w_stage_nxt = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_stage_end) begin
      if (r_stage == STAGE_LAST) begin
        w_state_nxt = ST_DONE;
      end else begin
        w_state_nxt = ST_RUN;
        w_stage_nxt = r_stage + STAGE_W'(1);
        w_k_nxt     = '0;
      end
    end
  end

  // Outputs are computed from the next state so the registered values line
  // up with the registered out_valid; a stalled handshake keeps stage/k, so
  // the addresses hold by construction.
  assign w_run_nxt = (w_state_nxt == ST_RUN);
  assign w_bfly    = bfly_addr(w_stage_nxt, w_k_nxt);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_k      <= '0;
      r_stage  <= '0;
      r_drain  <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_last   <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_tw     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state  <= w_state_nxt;
      r_k      <= w_k_nxt;
      r_stage  <= w_stage_nxt;
      r_drain  <= w_drain_nxt;
      r_valid  <= w_run_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_done   <= (w_state_nxt == ST_DONE);
      r_last   <= w_run_nxt && (w_k_nxt == K_LAST);
      r_addr_a <= w_run_nxt ? w_bfly.a  : '0;
      r_addr_b <= w_run_nxt ? w_bfly.b  : '0;
      r_tw     <= w_run_nxt ? w_bfly.tw : '0;
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign out_valid     = r_valid;
  assign addr_a        = r_addr_a;
  assign addr_b        = r_addr_b;
  assign tw_idx        = r_tw;
  assign stage         = r_stage;
  assign last_in_stage = r_last;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Scoreboard bench for ntt_addr_gen. Three instances cover LOG_N=3 with a
// two-cycle drain, LOG_N=3 with no drain, and LOG_N=10. The expected
// butterfly order comes from a nested group/position loop model.
module tb_ntt_addr_gen;
  import ntt_pkg::*;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic        busy;
    logic        done;
    logic [4:0]  stage;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] tw;
  } obs_t;

  typedef struct packed {
    logic [4:0]  stage;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] tw;
    logic        last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v;
  logic [2:0] ready_v;

  always #5 clk = ~clk;

  // Instance A: LOG_N=3, DRAIN_CYCLES=2
  logic a_busy, a_done, a_valid, a_last;
  logic [2:0] a_addr_a, a_addr_b;
  logic [1:0] a_tw;
  logic [STAGE_W-1:0] a_stage;
  // Instance Z: LOG_N=3, DRAIN_CYCLES=0
  logic z_busy, z_done, z_valid, z_last;
  logic [2:0] z_addr_a, z_addr_b;
  logic [1:0] z_tw;
  logic [STAGE_W-1:0] z_stage;
  // Instance B: LOG_N=10, DRAIN_CYCLES=2
  logic b_busy, b_done, b_valid, b_last;
  logic [9:0] b_addr_a, b_addr_b;
  logic [8:0] b_tw;
  logic [STAGE_W-1:0] b_stage;

  ntt_addr_gen #(.LOG_N(3), .DRAIN_CYCLES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(a_busy), .done(a_done),
    .out_valid(a_valid), .out_ready(ready_v[0]), .addr_a(a_addr_a), .addr_b(a_addr_b),
    .tw_idx(a_tw), .stage(a_stage), .last_in_stage(a_last));

  ntt_addr_gen #(.LOG_N(3), .DRAIN_CYCLES(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(z_busy), .done(z_done),
    .out_valid(z_valid), .out_ready(ready_v[1]), .addr_a(z_addr_a), .addr_b(z_addr_b),
    .tw_idx(z_tw), .stage(z_stage), .last_in_stage(z_last));

  ntt_addr_gen #(.LOG_N(10), .DRAIN_CYCLES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(b_busy), .done(b_done),
    .out_valid(b_valid), .out_ready(ready_v[2]), .addr_a(b_addr_a), .addr_b(b_addr_b),
    .tw_idx(b_tw), .stage(b_stage), .last_in_stage(b_last));

  obs_t obs_a, obs_z, obs_b;
  assign obs_a = '{valid: a_valid, last: a_last, busy: a_busy, done: a_done, stage: a_stage,
                   a: 16'(a_addr_a), b: 16'(a_addr_b), tw: 16'(a_tw)};
  assign obs_z = '{valid: z_valid, last: z_last, busy: z_busy, done: z_done, stage: z_stage,
                   a: 16'(z_addr_a), b: 16'(z_addr_b), tw: 16'(z_tw)};
  assign obs_b = '{valid: b_valid, last: b_last, busy: b_busy, done: b_done, stage: b_stage,
                   a: 16'(b_addr_a), b: 16'(b_addr_b), tw: 16'(b_tw)};

  int   n_err = 0;
  int   n_chk = 0;
  exp_t sb[$];
  int   done_q[$];
  int   gap_q[$];
  obs_t hist[$];
  int   valid_cnt;
  int   hs_cnt;
  int   max_tw;
  int   hits[0:9][0:1023];

  function automatic obs_t get_obs(input int sel);
    case (sel)
      0:       return obs_a;
      1:       return obs_z;
      default: return obs_b;
    endcase
  endfunction

  function automatic exp_t tuple_of(input obs_t o);
    return '{stage: o.stage, a: o.a, b: o.b, tw: o.tw, last: o.last};
  endfunction

  // Reference order: for each stage, walk groups of width 2*half, and inside
  // each group pair position j with j+half; twiddle step is N/(2*half).
  task automatic push_model(input int log_n);
    int n;
    int half;
    int cnt;
    exp_t e;
    n = 1 << log_n;
    for (int s = 0; s < log_n; s++) begin
      half = 1 << s;
      cnt  = 0;
      for (int base = 0; base < n; base += 2 * half) begin
        for (int j = 0; j < half; j++) begin
          e.stage = 5'(s);
          e.a     = 16'(base + j);
          e.b     = 16'(base + j + half);
          e.tw    = 16'(j * (n / (2 * half)));
          e.last  = (cnt == n / 2 - 1);
          sb.push_back(e);
          cnt++;
        end
      end
    end
  endtask

  // Start a transform on instance sel and follow it cycle by cycle.
  // mode: 0 ready=1, 1 ready pattern 1,0,0,1, 2 random ready.
  // start is held for cycles < release_cyc and pulsed again at restart_cyc.
  task automatic run_xfer(input int sel, input int log_n, input int mode,
                          input int restart_cyc, input int release_cyc,
                          input int exp_dones, input int budget);
    obs_t o;
    obs_t prev;
    exp_t e;
    exp_t got;
    bit   prev_stall;
    bit   seen_valid;
    bit   finished;
    int   gap;
    int   n_done;
    int   after;
    sb.delete();
    done_q.delete();
    gap_q.delete();
    hist.delete();
    valid_cnt = 0;
    hs_cnt    = 0;
    max_tw    = 0;
    for (int s = 0; s < 10; s++)
      for (int a = 0; a < 1024; a++) hits[s][a] = 0;
    for (int r = 0; r < exp_dones; r++) push_model(log_n);
    prev       = '0;
    prev_stall = 1'b0;
    seen_valid = 1'b0;
    finished   = 1'b0;
    gap        = 0;
    n_done     = 0;
    after      = 0;
    @(posedge clk); #1;
    start_v[sel] = 1'b1;
    @(posedge clk); #1;   // start-accept edge; cycle 0 follows
    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      start_v[sel] = (cyc < release_cyc) || (cyc == restart_cyc);
      case (mode)
        0:       ready_v[sel] = 1'b1;
        1:       ready_v[sel] = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: ready_v[sel] = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      o = get_obs(sel);
      hist.push_back(o);
      if (prev_stall) begin
        n_chk++;
        if (!o.valid || tuple_of(o) !== tuple_of(prev)) begin
          n_err++;
          $display("FAIL hold sel=%0d cyc=%0d got v=%0d a=%0d b=%0d tw=%0d last=%0d want a=%0d b=%0d tw=%0d last=%0d",
                   sel, cyc, o.valid, o.a, o.b, o.tw, o.last, prev.a, prev.b, prev.tw, prev.last);
        end
      end
      if (o.valid) begin
        if (seen_valid && gap > 0) gap_q.push_back(gap);
        gap        = 0;
        seen_valid = 1'b1;
        valid_cnt++;
        if (ready_v[sel]) begin
          hs_cnt++;
          n_chk++;
          got = tuple_of(o);
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL extra_bfly sel=%0d cyc=%0d got st=%0d a=%0d b=%0d, want none",
                     sel, cyc, got.stage, got.a, got.b);
          end else begin
            e = sb.pop_front();
            if (got !== e) begin
              n_err++;
              $display("FAIL seq sel=%0d cyc=%0d got st=%0d a=%0d b=%0d tw=%0d last=%0d want st=%0d a=%0d b=%0d tw=%0d last=%0d",
                       sel, cyc, got.stage, got.a, got.b, got.tw, got.last,
                       e.stage, e.a, e.b, e.tw, e.last);
            end
          end
          if (o.stage < 10 && o.a < 1024 && o.b < 1024) begin
            hits[o.stage][o.a]++;
            hits[o.stage][o.b]++;
          end
          if (int'(o.tw) > max_tw) max_tw = int'(o.tw);
        end
      end else begin
        if (seen_valid) gap++;
        n_chk++;
        if (o.last !== 1'b0) begin
          n_err++;
          $display("FAIL last_when_idle sel=%0d cyc=%0d got %0d want 0", sel, cyc, o.last);
        end
      end
      if (o.done) begin
        n_done++;
        done_q.push_back(cyc);
        seen_valid = 1'b0;
        gap        = 0;
      end
      prev       = o;
      prev_stall = o.valid && !ready_v[sel];
      if (n_done >= exp_dones) after++;
      finished = (after > 2);
      @(posedge clk); #1;
    end
    start_v[sel] = 1'b0;
    ready_v[sel] = 1'b0;
    n_chk++;
    if (!finished) begin
      n_err++;
      $display("FAIL timeout sel=%0d got dones=%0d want %0d within %0d cycles",
               sel, n_done, exp_dones, budget);
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL missing_bfly sel=%0d got %0d left want 0", sel, sb.size());
    end
    n_chk++;
    if (n_done != exp_dones) begin
      n_err++;
      $display("FAIL done_count sel=%0d got %0d want %0d", sel, n_done, exp_dones);
    end
    sb.delete();
  endtask

  task automatic check_done_at(input string name, input int idx, input int want);
    int got;
    got = (done_q.size() > idx) ? done_q[idx] : -1;
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got done cycle %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset;
    #12;
    n_chk++;
    if (obs_a !== '0) begin n_err++; $display("FAIL reset_a got %h want 0", obs_a); end
    n_chk++;
    if (obs_z !== '0) begin n_err++; $display("FAIL reset_z got %h want 0", obs_z); end
    n_chk++;
    if (obs_b !== '0) begin n_err++; $display("FAIL reset_b got %h want 0", obs_b); end
    #10 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (obs_a !== '0) begin n_err++; $display("FAIL idle_a got %h want 0", obs_a); end
  endtask

  task automatic test_basic;
    bit ok_v;
    bit ok_b;
    run_xfer(0, 3, 0, -1, 0, 1, 100);
    check_done_at("basic_done", 0, 18);
    n_chk++;
    if (gap_q.size() != 2 || gap_q[0] != 2 || gap_q[1] != 2) begin
      n_err++;
      $display("FAIL basic_gaps got %0d gaps (first %0d) want 2 gaps of 2",
               gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1);
    end
    n_chk++;
    if (valid_cnt != 12) begin
      n_err++;
      $display("FAIL basic_valid_cnt got %0d want 12", valid_cnt);
    end
    ok_v = 1'b1;
    ok_b = 1'b1;
    for (int i = 0; i < 18; i++) if (hist[i].valid !== ((i % 6) < 4)) ok_v = 1'b0;
    for (int i = 0; i < 19; i++) if (hist[i].busy !== 1'b1) ok_b = 1'b0;
    for (int i = 19; i < hist.size(); i++) if (hist[i].busy !== 1'b0) ok_b = 1'b0;
    n_chk++;
    if (!ok_v) begin n_err++; $display("FAIL basic_valid_pattern got mismatch want 4 on/2 off"); end
    n_chk++;
    if (!ok_b) begin n_err++; $display("FAIL basic_busy got mismatch want high cycles 0..18 only"); end
  endtask

  task automatic test_backpressure;
    run_xfer(0, 3, 1, -1, 0, 1, 200);
    n_chk++;
    if (gap_q.size() != 2 || gap_q[0] != 2 || gap_q[1] != 2) begin
      n_err++;
      $display("FAIL bp_gaps got %0d gaps want 2 gaps of 2", gap_q.size());
    end
  endtask

  task automatic test_no_drain;
    bit ok;
    run_xfer(1, 3, 0, -1, 0, 1, 100);
    check_done_at("nodrain_done", 0, 12);
    ok = 1'b1;
    for (int i = 0; i < 12; i++) if (hist[i].valid !== 1'b1) ok = 1'b0;
    if (hist[12].valid !== 1'b0) ok = 1'b0;
    n_chk++;
    if (!ok || gap_q.size() != 0) begin
      n_err++;
      $display("FAIL nodrain_valid got gaps=%0d want 12 back-to-back valid, no gap", gap_q.size());
    end
  endtask

  task automatic test_restart;
    run_xfer(0, 3, 0, 7, 0, 1, 100);
    check_done_at("restart_done", 0, 18);
  endtask

  task automatic test_back_to_back;
    run_xfer(0, 3, 0, -1, 20, 2, 200);
    check_done_at("b2b_done1", 0, 18);
    check_done_at("b2b_done2", 1, 38);
    n_chk++;
    if (hist[19].busy !== 1'b0 || hist[19].valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle got busy=%0d valid=%0d want 0 0", hist[19].busy, hist[19].valid);
    end
    n_chk++;
    if (hist[20].valid !== 1'b1 || hist[20].a !== 16'd0 || hist[20].b !== 16'd1 ||
        hist[20].stage !== 5'd0) begin
      n_err++;
      $display("FAIL b2b_restart got v=%0d a=%0d b=%0d st=%0d want 1 0 1 0",
               hist[20].valid, hist[20].a, hist[20].b, hist[20].stage);
    end
  endtask

  task automatic test_reset_mid;
    bit found;
    bit saw_done;
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    ready_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (obs_a.valid && obs_a.stage == 5'd1 && obs_a.a == 16'd1) found = 1'b1;
    end
    n_chk++;
    if (!found) begin n_err++; $display("FAIL rstmid_reach got no stage1 want stage1 bfly"); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs_a !== '0) begin n_err++; $display("FAIL rstmid_async got %h want 0", obs_a); end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (obs_a.done) saw_done = 1'b1;
    end
    n_chk++;
    if (saw_done || obs_a !== '0) begin
      n_err++;
      $display("FAIL rstmid_hold got done=%0d obs=%h want 0 0", saw_done, obs_a);
    end
    rst_n      = 1'b1;
    ready_v[0] = 1'b0;
    run_xfer(0, 3, 0, -1, 0, 1, 100);
    check_done_at("rstmid_rerun_done", 0, 18);
  endtask

  task automatic test_random_10;
    int bad;
    run_xfer(2, 10, 2, -1, 0, 1, 40000);
    n_chk++;
    if (hs_cnt != 5120) begin n_err++; $display("FAIL r10_count got %0d want 5120", hs_cnt); end
    for (int s = 0; s < 10; s++) begin
      bad = 0;
      for (int a = 0; a < 1024; a++) if (hits[s][a] != 1) bad++;
      n_chk++;
      if (bad != 0) begin
        n_err++;
        $display("FAIL r10_cover stage=%0d got %0d addresses not touched once want 0", s, bad);
      end
    end
    n_chk++;
    if (max_tw >= 512) begin n_err++; $display("FAIL r10_tw got max %0d want < 512", max_tw); end
    n_chk++;
    if (gap_q.size() != 9) begin n_err++; $display("FAIL r10_gaps got %0d want 9", gap_q.size()); end
  endtask

  initial begin
    rst_n   = 1'b0;
    start_v = '0;
    ready_v = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_no_drain();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    test_random_10();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
